// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with pending-write scoreboard.
//   Purpose : NRP zero-latency read ports, one synchronous write port, x0 hardwired
//             to zero, optional write-first bypass, and a per-register pending bit
//             set at issue and cleared at writeback for decode hazard checks.
//   Ports   :
//     clk       - clock, all state updates on the rising edge
//     rst_n     - asynchronous active-low reset, clears all state
//     rd_addr   - NRP packed read addresses, port i at [i*AW +: AW]
//     rd_data   - NRP packed read data, port i at [i*XLEN +: XLEN] (combinational)
//     rd_busy   - per-port: addressed register has an outstanding write (combinational)
//     wr_en     - write enable
//     wr_addr   - write address
//     wr_data   - write data
//     iss_en    - issue strobe, marks iss_addr pending
//     iss_addr  - destination register of the issuing instruction
//     pend_cnt  - registered count of pending registers
//     busy_any  - registered, pend_cnt != 0
module regfile_sb #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned NRP    = 2,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned AW    = $clog2(NREG),
    localparam int unsigned CW    = AW + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRP*AW-1:0]   rd_addr,
    output logic [NRP*XLEN-1:0] rd_data,
    output logic [NRP-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic [CW-1:0]       pend_cnt,
    output logic                busy_any
);

    logic [XLEN-1:0] r_rf [NREG];
    logic [NREG-1:0] r_pend;
    logic [CW-1:0]   r_cnt;
    logic            r_busy_any;

    logic            w_wr_do;
    logic            w_wr_fwd;
    logic            w_set;
    logic            w_clr;
    logic            w_inc;
    logic            w_dec;
    logic [NREG-1:0] w_pend_nxt;
    logic [CW-1:0]   w_cnt_nxt;

    // Architectural write qualifier: x0 writes are dropped.
    assign w_wr_do  = wr_en && (wr_addr != '0);
    // Forwarding/clear-visibility qualifier; suppressed while reset is held so
    // reads stay zero during reset even if wr_en is asserted.
    assign w_wr_fwd = wr_en && rst_n;

    assign w_set = iss_en && (iss_addr != '0);
    assign w_clr = w_wr_do;

    // Register storage; entry 0 is never written and stays zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
        end else if (w_wr_do) begin
            r_rf[wr_addr] <= wr_data;
        end
    end

    // Next pending vector: clear first, then set, so a same-register
    // issue/writeback leaves the bit set (the issuing writer is younger).
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_clr) begin
            w_pend_nxt[wr_addr] = 1'b0;
        end
        if (w_set) begin
            w_pend_nxt[iss_addr] = 1'b1;
        end
        w_pend_nxt[0] = 1'b0;
    end

    // Count delta: increment only on a 0->1 transition, decrement only on a
    // real 1->0 transition (a clear overridden by a same-register set is not).
    always_comb begin
        w_inc     = w_set && !r_pend[iss_addr];
        w_dec     = w_clr && r_pend[wr_addr] && !(w_set && (iss_addr == wr_addr));
        w_cnt_nxt = r_cnt + CW'(w_inc) - CW'(w_dec);
    end

    // Scoreboard state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend     <= '0;
            r_cnt      <= '0;
            r_busy_any <= 1'b0;
        end else begin
            r_pend     <= w_pend_nxt;
            r_cnt      <= w_cnt_nxt;
            r_busy_any <= (w_cnt_nxt != '0);
        end
    end

    assign pend_cnt = r_cnt;
    assign busy_any = r_busy_any;

    // Read ports, each fully independent.
    for (genvar p = 0; p < NRP; p++) begin : g_rd
        logic [AW-1:0]   w_ra;
        logic            w_zero;
        logic            w_hit;
        logic [XLEN-1:0] w_rdata;

        assign w_ra   = rd_addr[p*AW +: AW];
        assign w_zero = (w_ra == '0);
        assign w_hit  = w_wr_fwd && (wr_addr == w_ra);

        // Write-first forwarding only when BYPASS is enabled.
        assign w_rdata = w_zero                     ? '0      :
                         ((BYPASS != 0) && w_hit)   ? wr_data :
                                                      r_rf[w_ra];

        assign rd_data[p*XLEN +: XLEN] = w_rdata;

        // A writeback in this cycle retires the hazard immediately,
        // regardless of BYPASS; a same-cycle issue is not yet visible.
        assign rd_busy[p] = !w_zero && r_pend[w_ra] && !w_hit;
    end

endmodule
